imm_extend_pipe: RTL and testbench

//  Parametrised immediate extraction and extension stage for the LC-3 datapath.

---
 rtl/imm_extend_pipe.sv | 99 +++++++++
 tb/tb_imm_extend_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// LC-3 immediate field extraction/extension stage with a registered output and a
// one-entry skid register, so upstream stalls never depend combinationally on out_ready.
module imm_extend_pipe #(
  parameter int IR_W   = 16,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [2:0]        in_mode,
  input  logic              in_shl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam logic [2:0] MODE_IMM5  = 3'd0;
  localparam logic [2:0] MODE_OFF6  = 3'd1;
  localparam logic [2:0] MODE_OFF9  = 3'd2;
  localparam logic [2:0] MODE_OFF11 = 3'd3;
  localparam logic [2:0] MODE_TRAP8 = 3'd4;

  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] new_data;
  logic              new_err;

  logic              or_valid_reg;
  logic [DATA_W-1:0] or_data_reg;
  logic              or_err_reg;
  logic              sk_valid_reg;
  logic [DATA_W-1:0] sk_data_reg;
  logic              sk_err_reg;

  logic acc;
  logic ret;

  // Field select and extension; bits of in_ir above the chosen field never reach ext.
  always_comb begin
    ext     = '0;
    new_err = 1'b0;
    case (in_mode)
      MODE_IMM5:  ext = {{(DATA_W-5){in_ir[4]}},   in_ir[4:0]};
      MODE_OFF6:  ext = {{(DATA_W-6){in_ir[5]}},   in_ir[5:0]};
      MODE_OFF9:  ext = {{(DATA_W-9){in_ir[8]}},   in_ir[8:0]};
      MODE_OFF11: ext = {{(DATA_W-11){in_ir[10]}}, in_ir[10:0]};
      MODE_TRAP8: ext = {{(DATA_W-8){1'b0}},       in_ir[7:0]};
      default:    new_err = 1'b1;
    endcase
  end

  // Shift drops the MSB of ext; reserved modes force zero regardless of in_shl.
  always_comb begin
    new_data = '0;
    if (!new_err) begin
      new_data = in_shl ? {ext[DATA_W-2:0], 1'b0} : ext;
    end
  end

  assign in_ready  = ~sk_valid_reg;
  assign out_valid = or_valid_reg;
  assign out_data  = or_data_reg;
  assign out_err   = or_err_reg;

  assign acc = in_valid & in_ready;
  assign ret = or_valid_reg & out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      or_valid_reg <= 1'b0;
      or_data_reg  <= '0;
      or_err_reg   <= 1'b0;
      sk_valid_reg <= 1'b0;
      sk_data_reg  <= '0;
      sk_err_reg   <= 1'b0;
    end else if (!or_valid_reg || ret) begin
      // Output slot is free this cycle: the skid entry is older, so it goes first.
      if (sk_valid_reg) begin
        or_valid_reg <= 1'b1;
        or_data_reg  <= sk_data_reg;
        or_err_reg   <= sk_err_reg;
        sk_valid_reg <= 1'b0;
      end else if (acc) begin
        or_valid_reg <= 1'b1;
        or_data_reg  <= new_data;
        or_err_reg   <= new_err;
      end else begin
        or_valid_reg <= 1'b0;
      end
    end else if (acc) begin
      sk_valid_reg <= 1'b1;
      sk_data_reg  <= new_data;
      sk_err_reg   <= new_err;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: extension modes, backpressure ordering,
// full-rate streaming and reset while the buffer holds two entries.
module tb_imm_extend_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ir;
  logic [2:0]  in_mode;
  logic        in_shl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe #(.IR_W(16), .DATA_W(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_mode   (in_mode),
    .in_shl    (in_shl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word with out_ready high, check it one cycle later, then check it retires.
  task automatic one(input string tag, input logic [15:0] ir, input logic [2:0] mode,
                     input logic shl, input logic [15:0] exp_data, input logic exp_err);
    in_valid  = 1'b1;
    in_ir     = ir;
    in_mode   = mode;
    in_shl    = shl;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_err"}, {15'd0, out_err}, {15'd0, exp_err});
    tick();
    chk({tag, "_retired"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    logic [15:0] exp_k;

    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_ir     = '0;
    in_mode   = '0;
    in_shl    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_err", {15'd0, out_err}, 16'd0);

    // Extension vectors
    one("imm5_neg",    16'h001F, 3'd0, 1'b0, 16'hFFFF, 1'b0);
    one("imm5_pos",    16'h000F, 3'd0, 1'b0, 16'h000F, 1'b0);
    one("imm5_upper",  16'hFFE0, 3'd0, 1'b0, 16'h0000, 1'b0);
    one("off11_neg",   16'h0400, 3'd3, 1'b0, 16'hFC00, 1'b0);
    one("off6_neg",    16'hFFE0, 3'd1, 1'b0, 16'hFFE0, 1'b0);
    one("off6_upper",  16'hFFD0, 3'd1, 1'b0, 16'h0010, 1'b0);
    one("trap8",       16'hF0FF, 3'd4, 1'b0, 16'h00FF, 1'b0);
    one("off9_shl",    16'h01FF, 3'd2, 1'b1, 16'hFFFE, 1'b0);
    one("off11_shl",   16'h0400, 3'd3, 1'b1, 16'hF800, 1'b0);
    one("trap8_shl",   16'h00FF, 3'd4, 1'b1, 16'h01FE, 1'b0);
    one("off9_pos",    16'hFE55, 3'd2, 1'b0, 16'h0055, 1'b0);
    one("mode6",       16'hFFFF, 3'd6, 1'b0, 16'h0000, 1'b1);
    one("mode5_shl",   16'hFFFF, 3'd5, 1'b1, 16'h0000, 1'b1);
    one("mode7",       16'h1234, 3'd7, 1'b0, 16'h0000, 1'b1);

    // Backpressure: 1 and 2 buffered, 3 waits
    out_ready = 1'b0;
    in_mode   = 3'd0;
    in_shl    = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 16'h0001;
    tick();
    chk("bp_w1_data", out_data, 16'h0001);
    chk("bp_w1_ready", {15'd0, in_ready}, 16'd1);
    in_ir = 16'h0002;
    tick();
    chk("bp_w2_hold", out_data, 16'h0001);
    chk("bp_w2_ready", {15'd0, in_ready}, 16'd0);
    in_ir = 16'h0003;
    tick();
    chk("bp_stall_data", out_data, 16'h0001);
    chk("bp_stall_valid", {15'd0, out_valid}, 16'd1);
    chk("bp_stall_ready", {15'd0, in_ready}, 16'd0);
    tick();
    chk("bp_stall2_data", out_data, 16'h0001);
    out_ready = 1'b1;
    tick();
    chk("bp_out2", out_data, 16'h0002);
    chk("bp_out2_ready", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_out3", out_data, 16'h0003);
    chk("bp_out3_valid", {15'd0, out_valid}, 16'd1);
    tick();
    chk("bp_drained", {15'd0, out_valid}, 16'd0);

    // Full-rate streaming of 20 imm5 words
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_ir = 16'(k);
      tick();
      exp_k = (k < 16) ? 16'(k) : (16'(k) | 16'hFFE0);
      chk($sformatf("tp%0d_valid", k), {15'd0, out_valid}, 16'd1);
      chk($sformatf("tp%0d_data", k), out_data, exp_k);
      chk($sformatf("tp%0d_ready", k), {15'd0, in_ready}, 16'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("tp_drained", {15'd0, out_valid}, 16'd0);

    // Reset with two entries buffered; the word offered during reset is dropped
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 16'h0005;
    tick();
    in_ir = 16'h0006;
    tick();
    chk("rs_full_ready", {15'd0, in_ready}, 16'd0);
    Reset = 1'b1;
    in_ir = 16'h0007;
    tick();
    Reset    = 1'b0;
    in_valid = 1'b0;
    chk("rs_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rs_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rs_out_data", out_data, 16'h0000);
    chk("rs_out_err", {15'd0, out_err}, 16'd0);
    one("rs_first", 16'h000A, 3'd0, 1'b0, 16'h000A, 1'b0);
    tick();
    chk("rs_no_stale", {15'd0, out_valid}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
